// File: rtl/cmd_seq_proc.sv
// Queued command processor for the line follower: buffers route commands and
// executes each as a sequence of 2-bit legs, with bumper debounce, pause/resume and halt.
module cmd_seq_proc #(
  parameter int unsigned CMD_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TMR_W      = 27,
  parameter int unsigned DB_CYCLES  = 16,
  parameter int unsigned T_BUMP     = 5_000_000,
  parameter int unsigned T_TURN_A   = 46_150_000,
  parameter int unsigned T_TURN_B   = 65_000_000,
  parameter logic [15:0] VEER_ERR   = 16'h340,
  parameter logic [15:0] TURN_A_ERR = 16'h1E0,
  parameter logic [15:0] TURN_B_ERR = 16'h380,
  parameter int unsigned BUZZ_HALF  = 6250
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CMD_W-1:0] cmd,
  input  logic             cmd_rdy,
  output logic             clr_cmd_rdy,
  input  logic             line_present,
  input  logic             BMPL_n,
  input  logic             BMPR_n,
  output logic             go,
  output logic [15:0]      err_opn_lp,
  output logic             err_opn_lp_en,
  output logic             buzz,
  output logic             busy,
  output logic             fifo_full,
  output logic             fifo_empty
);

  localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned DBW = $clog2(DB_CYCLES + 1);
  localparam int unsigned BZW = $clog2(BUZZ_HALF + 1);
  localparam logic [TMR_W-1:0] TMR_BUMP = TMR_W'(T_BUMP - 1);
  localparam logic [TMR_W-1:0] TMR_TA   = TMR_W'(T_TURN_A - 1);
  localparam logic [TMR_W-1:0] TMR_TB   = TMR_W'(T_TURN_B - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FOLLOW, S_VEER, S_TURN_A, S_TURN_B, S_BUMP, S_HALT
  } state_t;

  state_t           r_state, w_next;
  logic [CMD_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_cnt;
  logic             r_clr;
  logic [CMD_W-1:0] r_leg;
  logic [TMR_W-1:0] r_tmr;
  logic [1:0]       r_sync;
  logic [DBW-1:0]   r_db_cnt;
  logic             r_bump_db, r_bump_prev;
  logic             r_last_rght;
  logic [BZW-1:0]   r_bz_cnt;
  logic             r_buzz;

  logic             w_full, w_empty, w_push, w_pop, w_adv;
  logic             w_raw, w_bump_edge, w_buzz_st;
  logic             w_go, w_en;
  logic [15:0]      w_err;

  assign w_full  = (r_cnt == (AW+1)'(FIFO_DEPTH));
  assign w_empty = (r_cnt == '0);
  // No write in the pulse cycle: the wrapper still holds cmd_rdy while it sees clr.
  assign w_push  = cmd_rdy && !r_clr && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= cmd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_clr  <= 1'b0;
    end else begin
      r_clr <= w_push;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign w_raw       = !BMPL_n | !BMPR_n;
  assign w_bump_edge = r_bump_db & ~r_bump_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync      <= '0;
      r_db_cnt    <= '0;
      r_bump_db   <= 1'b0;
      r_bump_prev <= 1'b0;
    end else begin
      r_sync      <= {r_sync[0], w_raw};
      r_bump_prev <= r_bump_db;
      if (r_sync[1] == r_bump_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DBW'(DB_CYCLES - 1)) begin
        r_db_cnt  <= '0;
        r_bump_db <= ~r_bump_db;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    w_adv  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && line_present) begin
          w_pop  = 1'b1;
          w_next = S_FOLLOW;
        end
      end
      S_FOLLOW: begin
        if (r_bump_db) begin
          w_next = S_BUMP;
        end else if (!line_present) begin
          case (r_leg[1:0])
            2'b00:   w_next = S_IDLE;
            2'b11:   w_next = S_TURN_A;
            default: w_next = S_VEER;
          endcase
        end
      end
      S_VEER: begin
        if (r_bump_db) begin
          w_next = S_BUMP;
        end else if (line_present) begin
          w_adv  = 1'b1;
          w_next = S_FOLLOW;
        end
      end
      S_TURN_A: begin
        if (r_tmr >= TMR_TA) w_next = S_TURN_B;
      end
      S_TURN_B: begin
        if (r_tmr >= TMR_TB && line_present) begin
          w_adv  = 1'b1;
          w_next = S_FOLLOW;
        end
      end
      S_BUMP: begin
        if (!r_bump_db)            w_next = S_FOLLOW;
        else if (r_tmr >= TMR_BUMP) w_next = S_HALT;
      end
      S_HALT: begin
        if (w_bump_edge) w_next = S_FOLLOW;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_tmr       <= '0;
      r_leg       <= '0;
      r_last_rght <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state != w_next)  r_tmr <= '0;
      else if (r_tmr != '1)   r_tmr <= r_tmr + 1'b1;
      if (w_pop)      r_leg <= r_mem[r_rptr];
      else if (w_adv) r_leg <= {2'b00, r_leg[CMD_W-1:2]};
      if (w_adv && r_state == S_VEER) r_last_rght <= r_leg[1];
    end
  end

  assign w_buzz_st = (r_state == S_BUMP) || (r_state == S_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bz_cnt <= '0;
      r_buzz   <= 1'b0;
    end else if (!w_buzz_st) begin
      r_bz_cnt <= '0;
      r_buzz   <= 1'b0;
    end else if (r_bz_cnt == BZW'(BUZZ_HALF - 1)) begin
      r_bz_cnt <= '0;
      r_buzz   <= ~r_buzz;
    end else begin
      r_bz_cnt <= r_bz_cnt + 1'b1;
    end
  end

  always_comb begin
    w_go  = 1'b0;
    w_en  = 1'b0;
    w_err = '0;
    case (r_state)
      S_FOLLOW: w_go = 1'b1;
      S_VEER: begin
        w_go  = 1'b1;
        w_en  = 1'b1;
        w_err = r_leg[1] ? VEER_ERR : -VEER_ERR;
      end
      S_TURN_A: begin
        w_go  = 1'b1;
        w_en  = 1'b1;
        w_err = r_last_rght ? -TURN_A_ERR : TURN_A_ERR;
      end
      S_TURN_B: begin
        w_go  = 1'b1;
        w_en  = 1'b1;
        w_err = r_last_rght ? TURN_B_ERR : -TURN_B_ERR;
      end
      default: ;
    endcase
  end

  assign go            = w_go;
  assign err_opn_lp_en = w_en;
  assign err_opn_lp    = w_err;
  assign buzz          = r_buzz & w_buzz_st;
  assign busy          = (r_state != S_IDLE);
  assign clr_cmd_rdy   = r_clr;
  assign fifo_full     = w_full;
  assign fifo_empty    = w_empty;

endmodule
